// File: rtl/gate_test_sequencer_if.sv
// Memory handshake bundle between the gate test sequencer (master) and the
// memory-owning processor (slave).
interface gate_test_sequencer_if;
  logic        mem_req;
  logic [7:0]  mem_cmd;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_ack;
  logic [7:0]  mem_rdata;

  modport master (output mem_req, mem_cmd, mem_addr, mem_wdata,
                  input  mem_ack, mem_rdata);
  modport slave  (input  mem_req, mem_cmd, mem_addr, mem_wdata,
                  output mem_ack, mem_rdata);
endinterface

// File: rtl/gate_test_sequencer.sv
// Per-vector read/apply/settle/capture/write-back sequencer for a gate tester.
// Optional GATE_TEST_STOP_ON_FAIL_EN ends the run after the first failing vector.
module gate_test_sequencer #(
  parameter int          IN_W       = 2,
  parameter int          OUT_W      = 1,
  parameter int          NUM_VEC    = 4,
  parameter int          SETTLE_CYC = 3,
  parameter logic [15:0] IN_BASE    = 16'h0008,
  parameter logic [15:0] EXP_BASE   = 16'h0010,
  parameter logic [15:0] RES_BASE   = 16'h0018
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  rx_done,
  gate_test_sequencer_if.master mem,
  output logic [IN_W-1:0]       dut_in,
  input  logic [OUT_W-1:0]      dut_resp,
  output logic [7:0]            dut_out,
  output logic                  busy,
  output logic                  done,
  output logic [8:0]            pass_cnt,
  output logic [8:0]            fail_cnt,
  output logic [7:0]            first_fail
);

`ifdef GATE_TEST_STOP_ON_FAIL_EN
  localparam bit STOP_ON_FAIL = 1'b1;
`else
  localparam bit STOP_ON_FAIL = 1'b0;
`endif

  localparam int              CNT_W     = $clog2(SETTLE_CYC + 1);
  localparam logic [7:0]      LAST_IDX  = 8'(NUM_VEC - 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE_CYC - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_WAIT_LOAD, S_RD_IN, S_RD_EXP, S_APPLY,
    S_SETTLE, S_CAPTURE, S_WR_RES, S_FINISH
  } state_e;

  state_e            state_q, state_d;
  logic              mem_req_q, mem_req_d;
  logic [7:0]        mem_cmd_q, mem_cmd_d;
  logic [15:0]       mem_addr_q, mem_addr_d;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic [IN_W-1:0]   dut_in_q, dut_in_d, in_vec_q, in_vec_d;
  logic [7:0]        dut_out_q, dut_out_d;
  logic              busy_q, busy_d, done_q, done_d;
  logic [8:0]        pass_cnt_q, pass_cnt_d, fail_cnt_q, fail_cnt_d;
  logic [7:0]        first_fail_q, first_fail_d, idx_q, idx_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OUT_W-1:0]  exp_vec_q, exp_vec_d, cap_q, cap_d;
  logic              fail_q, fail_d;
  logic [7:0]        res_byte;

  // Result byte: fail flag in bit 7, captured response in the low bits.
  always_comb begin
    res_byte = 8'h00;
    res_byte[OUT_W-1:0] = cap_q;
    res_byte[7] = fail_q;
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_cmd_d    = mem_cmd_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    dut_in_d     = dut_in_q;
    in_vec_d     = in_vec_q;
    dut_out_d    = dut_out_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    pass_cnt_d   = pass_cnt_q;
    fail_cnt_d   = fail_cnt_q;
    first_fail_d = first_fail_q;
    idx_d        = idx_q;
    cnt_d        = cnt_q;
    exp_vec_d    = exp_vec_q;
    cap_d        = cap_q;
    fail_d       = fail_q;
    case (state_q)
      S_IDLE: if (start) begin
        pass_cnt_d   = '0;
        fail_cnt_d   = '0;
        first_fail_d = 8'hFF;
        idx_d        = '0;
        busy_d       = 1'b1;
        state_d      = S_WAIT_LOAD;
      end
      S_WAIT_LOAD: if (rx_done) state_d = S_RD_IN;
      // Request goes out one cycle after state entry; ack only counts while requesting.
      S_RD_IN: if (!mem_req_q) begin
        mem_req_d  = 1'b1;
        mem_cmd_d  = 8'h00;
        mem_addr_d = IN_BASE + {8'h00, idx_q};
      end else if (mem.mem_ack) begin
        mem_req_d = 1'b0;
        in_vec_d  = mem.mem_rdata[IN_W-1:0];
        state_d   = S_RD_EXP;
      end
      S_RD_EXP: if (!mem_req_q) begin
        mem_req_d  = 1'b1;
        mem_cmd_d  = 8'h00;
        mem_addr_d = EXP_BASE + {8'h00, idx_q};
      end else if (mem.mem_ack) begin
        mem_req_d = 1'b0;
        exp_vec_d = mem.mem_rdata[OUT_W-1:0];
        state_d   = S_APPLY;
      end
      S_APPLY: begin
        dut_in_d = in_vec_q;
        cnt_d    = SETTLE_LD;
        state_d  = S_SETTLE;
      end
      S_SETTLE: if (cnt_q == '0) state_d = S_CAPTURE;
                else cnt_d = cnt_q - 1'b1;
      S_CAPTURE: begin
        cap_d     = dut_resp;
        dut_out_d = 8'(dut_resp);
        fail_d    = (dut_resp != exp_vec_q);
        if (dut_resp != exp_vec_q) begin
          fail_cnt_d = fail_cnt_q + 9'd1;
          if (first_fail_q == 8'hFF) first_fail_d = idx_q;
        end else begin
          pass_cnt_d = pass_cnt_q + 9'd1;
        end
        state_d = S_WR_RES;
      end
      S_WR_RES: if (!mem_req_q) begin
        mem_req_d   = 1'b1;
        mem_cmd_d   = 8'h01;
        mem_addr_d  = RES_BASE + {8'h00, idx_q};
        mem_wdata_d = res_byte;
      end else if (mem.mem_ack) begin
        mem_req_d = 1'b0;
        if (idx_q == LAST_IDX || (STOP_ON_FAIL && fail_q)) begin
          state_d = S_FINISH;
        end else begin
          idx_d   = idx_q + 8'd1;
          state_d = S_RD_IN;
        end
      end
      S_FINISH: begin
        done_d   = 1'b1;
        busy_d   = 1'b0;
        dut_in_d = '0;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      mem_req_q    <= 1'b0;
      mem_cmd_q    <= 8'h00;
      mem_addr_q   <= 16'h0000;
      mem_wdata_q  <= 8'h00;
      dut_in_q     <= '0;
      in_vec_q     <= '0;
      dut_out_q    <= 8'h00;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      first_fail_q <= 8'hFF;
      idx_q        <= '0;
      cnt_q        <= '0;
      exp_vec_q    <= '0;
      cap_q        <= '0;
      fail_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_cmd_q    <= mem_cmd_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      dut_in_q     <= dut_in_d;
      in_vec_q     <= in_vec_d;
      dut_out_q    <= dut_out_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      pass_cnt_q   <= pass_cnt_d;
      fail_cnt_q   <= fail_cnt_d;
      first_fail_q <= first_fail_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      exp_vec_q    <= exp_vec_d;
      cap_q        <= cap_d;
      fail_q       <= fail_d;
    end
  end

  assign mem.mem_req   = mem_req_q;
  assign mem.mem_cmd   = mem_cmd_q;
  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign dut_in        = dut_in_q;
  assign dut_out       = dut_out_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign pass_cnt      = pass_cnt_q;
  assign fail_cnt      = fail_cnt_q;
  assign first_fail    = first_fail_q;

endmodule

// File: doc/gate_test_sequencer.md
Name: gate_test_sequencer

Overview:
- Parametrised successor to the gate-tester verification controller. Runs a complete test of up to NUM_VEC input vectors against the DUT.
- Per vector: reads the input vector and the expected response from shared byte memory, drives the vector onto the DUT, waits a settle time, samples the DUT output and compares it to the expected value. It then writes a result byte back to memory and updates the pass/fail counters.
- Sits between the UART loader (rx_done) and the memory-owning processor (cmd/req/ack handshake), and drives the DUT pins and the LED display.

Parameters:
- IN_W, 2, DUT input width (1..8).
- OUT_W, 1, DUT output width (1..7).
- NUM_VEC, 4, vectors per run (1..256).
- SETTLE_CYC, 3, clk cycles between applying a vector and sampling the DUT (>=1).
- IN_BASE, 16'h0008, address of input vector 0.
- EXP_BASE, 16'h0010, address of expected vector 0.
- RES_BASE, 16'h0018, address of result byte 0.

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle pulse; begins a run when idle.
- rx_done  in  1  level: vector memory has been filled by the UART loader.
- mem_req  out  1  memory access request.
- mem_cmd  out  8  8'h00 = read, 8'h01 = write.
- mem_addr  out  16  access address.
- mem_wdata  out  8  write data.
- mem_ack  in  1  access complete; mem_rdata is valid in the ack cycle.
- mem_rdata  in  8  read data.
- dut_in  out  IN_W  drive to DUT inputs.
- dut_resp  in  OUT_W  DUT outputs, already synchronised externally.
- dut_out  out  8  last captured response, zero-extended, for the LEDs.
- busy  out  1  run in progress.
- done  out  1  one-cycle pulse at end of run.
- pass_cnt  out  9  passing vectors this run.
- fail_cnt  out  9  failing vectors this run.
- first_fail  out  8  index of the first failing vector; 8'hFF if none.

Behaviour:
- Reset (async, rst_n low) forces: state IDLE; mem_req=0; mem_cmd=8'h00; mem_addr=0; mem_wdata=0; dut_in=0; dut_out=0; busy=0; done=0; pass_cnt=0; fail_cnt=0; first_fail=8'hFF; internal idx=0; settle counter=0.
  - Reset mid-run abandons the run immediately. No memory write completes after rst_n falls.
- States:
  - IDLE: on start -> clear counters, set first_fail=8'hFF, idx=0, busy=1 -> WAIT_LOAD. Start while busy is ignored.
  - WAIT_LOAD: hold until rx_done=1 -> RD_IN. If rx_done is already high, exit on the next cycle.
  - RD_IN: mem_req=1, mem_cmd=00, mem_addr=IN_BASE+idx. On mem_ack, latch in_vec=mem_rdata[IN_W-1:0] and drop mem_req -> RD_EXP.
  - RD_EXP: same handshake at EXP_BASE+idx. Latch exp=mem_rdata[OUT_W-1:0] -> APPLY.
  - APPLY: dut_in<=in_vec; load settle counter with SETTLE_CYC-1 -> SETTLE.
  - SETTLE: decrement the counter. At 0 -> CAPTURE. dut_resp is sampled exactly SETTLE_CYC+1 cycles after the cycle in which dut_in updates.
  - CAPTURE: cap=dut_resp; dut_out<={0,cap}; fail=(cap!=exp). On fail, increment fail_cnt and, if first_fail==8'hFF, set first_fail=idx; otherwise increment pass_cnt -> WR_RES.
  - WR_RES: mem_req=1, mem_cmd=01, mem_addr=RES_BASE+idx, mem_wdata={fail, zero pad, cap[OUT_W-1:0]}. On mem_ack, if idx==NUM_VEC-1 -> FINISH; otherwise idx+1 -> RD_IN.
  - FINISH: done=1 for one cycle; busy=0; dut_in<=0 -> IDLE. Counters and first_fail hold until the next start.
- Handshake rules:
  - mem_req rises in the cycle after the state is entered.
  - mem_addr, mem_cmd and mem_wdata are stable while mem_req=1.
  - mem_req deasserts in the cycle after mem_ack is seen.
  - Ack may arrive any number of cycles later; there is no timeout.
  - mem_ack while mem_req=0 is ignored.
- Width and arithmetic rules:
  - Address arithmetic is 16-bit and wraps modulo 2^16.
  - Unused mem_rdata bits are ignored.
  - pass_cnt+fail_cnt==NUM_VEC at done.
- NUM_VEC=1: exactly one read/read/write cycle, then FINISH.

Optional Feature:
- Macro: GATE_TEST_STOP_ON_FAIL_EN.
- Defined: after the WR_RES ack of the first failing vector, go directly to FINISH. The remaining vectors are not read, and pass_cnt+fail_cnt equals idx+1.
- Undefined: every vector runs regardless of failures.

Test Plan:
- Setup: IN_W=2, OUT_W=1, NUM_VEC=4; DUT = AND gate; inputs 0,1,2,3; expected 0,0,0,1; ack after 2 cycles.
  -> Results at 0x18..0x1B = 00,00,00,01; pass_cnt=4; fail_cnt=0; first_fail=FF; one done pulse.
- Same setup, expected 0,1,0,1.
  -> Byte 0x19 = 8'h80; fail_cnt=1; pass_cnt=3; first_fail=1. With GATE_TEST_STOP_ON_FAIL_EN, the run ends after address 0x19 and pass_cnt=1.
- start with rx_done=0 for 20 cycles, then rx_done=1.
  -> No mem_req during the wait; the first read goes to 0x0008 after rx_done rises.
- SETTLE_CYC=5; DUT model updates its output 4 cycles after an input change.
  -> Correct value captured; dut_resp is sampled 6 cycles after dut_in changes.
- Pull rst_n low during WR_RES of vector 2 with ack pending.
  -> All outputs take reset values asynchronously, no write acked; a subsequent start runs cleanly from vector 0.
- Pulse start while busy, and assert a stray mem_ack while idle.
  -> Both are ignored; counters are unaffected.
